// File: rtl/acc_pkg.sv
// Shared defaults, FSM state type and counter sizing for the serial accumulator.
package acc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ACC_W  = 128;
  localparam int unsigned CNT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } acc_state_t;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/acc_sipo.sv
// Serial-in/parallel-out shift register with a down-counting bit counter.
// word_c/done_c are combinational so the word is usable on the edge that samples its LSB.
module acc_sipo #(
  parameter int unsigned WORD_W = acc_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              load,
  input  logic              shift,
  input  logic              rx,
  output logic [WORD_W-1:0] word_c,
  output logic              done_c
);
  import acc_pkg::*;

  localparam int unsigned BIT_CNT_W = cnt_width(WORD_W);

  logic [WORD_W-2:0]    sh;
  logic [BIT_CNT_W-1:0] cnt;

  // The incoming bit completes the word without waiting for another edge.
  assign word_c = {sh, rx};
  assign done_c = shift && (cnt == '0);

  always_ff @(posedge clk) begin
    if (nRst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= '0;
      cnt <= BIT_CNT_W'(WORD_W - 1);
    end else if (shift) begin
      sh  <= word_c[WORD_W-2:0];
      cnt <= cnt - BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/acc_serial.sv
// Bit-serial 32-bit word receiver feeding a wide running accumulator.
// Define ACC_OVF_EN to add the sticky carry-out flag `ovf`.
module acc_serial #(
  parameter int unsigned WORD_W = acc_pkg::WORD_W,
  parameter int unsigned ACC_W  = acc_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             rx,
  input  logic             add,
  input  logic             clear,
  output logic [ACC_W-1:0] big
`ifdef ACC_OVF_EN
  ,
  output logic             ovf
`endif
);
  import acc_pkg::*;

  acc_state_t        state;
  logic              load_c;
  logic              shift_c;
  logic              done_c;
  logic [WORD_W-1:0] word_c;

  // A low rx while enabled in IDLE is the start bit.
  assign load_c  = (state == IDLE) && add && !rx;
  assign shift_c = (state == SHIFT) && add;

  acc_sipo #(
    .WORD_W (WORD_W)
  ) u_sipo (
    .clk    (clk),
    .nRst   (nRst),
    .load   (load_c),
    .shift  (shift_c),
    .rx     (rx),
    .word_c (word_c),
    .done_c (done_c)
  );

`ifdef ACC_OVF_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  logic [ACC_W:0] sum_c;
  assign sum_c = {1'b0, big} + SUM_W'(word_c);
`else
  logic [ACC_W-1:0] sum_c;
  assign sum_c = big + ACC_W'(word_c);
`endif

  // Frame FSM plus accumulator; clear overrides a completing word but not the FSM.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state <= IDLE;
      big   <= '0;
`ifdef ACC_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (load_c) state <= SHIFT;
        SHIFT: begin
          if (!add)        state <= IDLE;
          else if (done_c) state <= WAIT;
        end
        WAIT:    if (!add) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (clear) begin
        big <= '0;
`ifdef ACC_OVF_EN
        ovf <= 1'b0;
`endif
      end else if (done_c) begin
        big <= sum_c[ACC_W-1:0];
`ifdef ACC_OVF_EN
        ovf <= ovf | sum_c[ACC_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_acc_serial.sv
// Self-checking bench for acc_serial: directed protocol cases plus random frames
// checked against a word-level sum model.
module tb_acc_serial;

`ifdef ACC_OVF_EN
  localparam int unsigned AW = 32;
`else
  localparam int unsigned AW = 128;
`endif
  localparam int unsigned AW1 = AW + 1;

  logic          clk   = 1'b0;
  logic          nRst  = 1'b1;
  logic          rx    = 1'b1;
  logic          add   = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] big;
`ifdef ACC_OVF_EN
  logic          ovf;
`endif

  logic [AW-1:0] exp_big = '0;
  logic          exp_ovf = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  acc_serial #(
    .WORD_W (32),
    .ACC_W  (AW)
  ) dut (
    .clk   (clk),
    .nRst  (nRst),
    .rx    (rx),
    .add   (add),
    .clear (clear),
    .big   (big)
`ifdef ACC_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accumulate(input logic [31:0] w);
    logic [AW:0] s;
    s       = {1'b0, exp_big} + AW1'(w);
    exp_big = s[AW-1:0];
    exp_ovf = exp_ovf | s[AW];
  endtask

  // One clock edge; `complete` means the stimulus intends this edge to deliver word w.
  task automatic step(input bit complete, input logic [31:0] w);
    bit rst_now = nRst;
    bit clr_now = clear;
    tick();
    if (rst_now || clr_now) begin
      exp_big = '0;
      exp_ovf = 1'b0;
    end else if (complete) begin
      accumulate(w);
    end
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk(tag, big, exp_big);
`ifdef ACC_OVF_EN
    chk({tag, "_ovf"}, AW'(ovf), AW'(exp_ovf));
`endif
  endtask

  // Start bit, nbits data bits (MSB first), then add low for `gap` edges.
  // clear is held high on frame edges 0..clr_edges-1 (edge 32 is the LSB).
  task automatic frame(input logic [31:0] w, input int nbits, input bit sbit,
                       input int clr_edges, input int gap);
    add   = 1'b1;
    rx    = sbit;
    clear = (clr_edges > 0);
    step(1'b0, w);
    for (int i = 0; i < nbits; i++) begin
      rx    = sbit ? 1'b1 : w[31-i];
      clear = (i + 1 < clr_edges);
      step(!sbit && (i == 31), w);
      if (i == 15) chk_all("mid");
      if (i == 31) chk_all("lsb");
    end
    add   = 1'b0;
    rx    = 1'b1;
    clear = 1'b0;
    for (int g = 0; g < gap; g++) step(1'b0, w);
    chk_all("gap");
  endtask

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    int          kind;

    // Reset
    nRst = 1'b1;
    repeat (3) step(1'b0, 32'd0);
    chk_all("reset");
    chk("reset_zero", big, '0);
    nRst = 1'b0;

    // Ten unit words with long gaps
    for (int k = 0; k < 10; k++) frame(32'h0000_0001, 32, 1'b0, 0, 100);
    chk("ten_ones", big, AW'(10));

    // Long clear, then ten 0x10000000 words
    clear = 1'b1;
    repeat (50) step(1'b0, 32'd0);
    clear = 1'b0;
    chk("clear_hold", big, '0);
    for (int k = 0; k < 10; k++) frame(32'h1000_0000, 32, 1'b0, 0, 2);
    chk("a0", big, AW'(32'hA000_0000));

    // clear held through entire frames discards every word
    for (int k = 0; k < 10; k++) frame(32'h0000_0001, 32, 1'b0, 33, 2);
    chk("clear_frames", big, '0);

    // Protocol errors
    frame(32'h1234_5678, 32, 1'b0, 0, 2);
    frame(32'hDEAD_BEEF, 16, 1'b0, 0, 2);
    chk("abort16", big, AW'(32'h1234_5678));
    frame(32'h0F0F_0F0F, 32, 1'b1, 0, 2);
    chk("bad_start", big, AW'(32'h1234_5678));

    // Two words back to back with add never dropping: only the first counts
    w1 = 32'h0000_0100;
    w2 = 32'h5555_AAAA;
    add = 1'b1;
    rx  = 1'b0;
    step(1'b0, w1);
    for (int i = 0; i < 32; i++) begin
      rx = w1[31-i];
      step(i == 31, w1);
    end
    chk_all("chain1");
    rx = 1'b0;
    step(1'b0, w2);
    for (int i = 0; i < 32; i++) begin
      rx = w2[31-i];
      step(1'b0, w2);
    end
    add = 1'b0;
    rx  = 1'b1;
    step(1'b0, w2);
    chk_all("chain2");
    chk("chain_val", big, AW'(32'h1234_5778));

    // clear released mid-frame: frame still completes
    frame(32'h0000_0777, 32, 1'b0, 10, 2);
    chk("straddle", big, AW'(32'h0000_0777));

    // Reset mid-frame, then a clean frame
    add = 1'b1;
    rx  = 1'b0;
    step(1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rx = 1'b1;
      step(1'b0, 32'd0);
    end
    nRst = 1'b1;
    add  = 1'b0;
    step(1'b0, 32'd0);
    nRst = 1'b0;
    chk_all("rst_mid");
    frame(32'h0000_0005, 32, 1'b0, 0, 2);
    chk("five", big, AW'(5));

`ifdef ACC_OVF_EN
    // Wrap-around sets the sticky flag; clear drops it
    clear = 1'b1;
    step(1'b0, 32'd0);
    clear = 1'b0;
    frame(32'hFFFF_FFFF, 32, 1'b0, 0, 2);
    frame(32'h0000_0002, 32, 1'b0, 0, 2);
    chk("ovf_big", big, AW'(1));
    chk("ovf_set", AW'(ovf), AW'(1));
    clear = 1'b1;
    step(1'b0, 32'd0);
    clear = 1'b0;
    chk_all("ovf_clr");
`endif

    // Random mix of good, aborted, bad-start and clear-straddled frames
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      w1   = $urandom;
      case (kind)
        2:       frame(w1, int'($urandom_range(0, 31)), 1'b0, 0, int'($urandom_range(1, 4)));
        3:       frame(w1, int'($urandom_range(0, 32)), 1'b1, 0, int'($urandom_range(1, 4)));
        4:       frame(w1, 32, 1'b0, int'($urandom_range(1, 33)), int'($urandom_range(1, 4)));
        default: frame(w1, 32, 1'b0, 0, int'($urandom_range(1, 4)));
      endcase
    end
    chk_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_serial.md
# acc_serial

Serial-input 128-bit accumulator. 32-bit words arrive MSB-first on a single-bit line, framed by an `add` enable and a start bit, and each completed word is added, zero-extended, into a running 128-bit sum. It sits behind a bit-serial link and provides a wide running total to downstream logic. A synchronous `clear` zeroes the sum.

## Interface
- `WORD_W`, default 32: serial word width; a frame carries this many data bits.
- `ACC_W`, default 128: accumulator width; must be greater than or equal to `WORD_W`.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `nRst`, input, 1: reset, synchronous and active-high, despite its name. While 1, `big`=0 and the FSM is in IDLE.
- `rx`, input, 1: serial data, sampled every rising edge.
- `add`, input, 1: frame enable; held high for the whole frame.
- `clear`, input, 1: synchronous clear of the sum.
- `big`, output, `ACC_W`: registered running sum.
- `ovf`, output, 1: sticky overflow flag; present only with `ACC_OVF_EN`.

## Operation
- FSM states are IDLE, SHIFT and WAIT. Every transition is a single-edge decision.
- IDLE → SHIFT when `add`=1 and `rx`=0 on the same edge; that `rx`=0 is the start bit. The bit counter is set to `WORD_W`−1.
- IDLE with `add`=1 and `rx`=1: no frame starts and the state stays IDLE.
- SHIFT, `add`=1: the shift register takes `{sh[WORD_W-2:0], rx}` and the counter decrements.
- When the counter is 0, the edge that samples the last bit (the LSB) also performs `big <= big + {zeros, sh[WORD_W-2:0], rx}`. The FSM then goes to WAIT.
- SHIFT with `add`=0 on any edge: the frame is aborted and discarded, `big` is unchanged, and the FSM returns to IDLE.
- WAIT → IDLE when `add`=0. A new frame needs `add` low for at least one edge.
- Addition is modulo 2^`ACC_W`; the carry out is dropped.
- `clear`=1: `big` is set to 0 on every edge it is held high. A word completing on a `clear` edge is discarded. The FSM keeps running while `clear` is high, so a frame that straddles the release of `clear` still completes normally.
- Priority, highest first: `nRst`, then `clear`, then completion of an addition.

## Timing
- Reset value: `big`=0 (and `ovf`=0). Reset mid-frame abandons the frame.
- A frame occupies 1+`WORD_W` consecutive edges (start bit plus 32 data bits).
- The updated `big` is visible immediately after the edge that samples data bit 0; there is no further latency.
- Minimum frame-to-frame spacing is `WORD_W`+2 edges, because of the mandatory one-edge `add`-low gap.
- `big` is a pure register output, with no combinational path from the inputs.

## Configuration
- Macro `ACC_OVF_EN`, when defined:
  - adds output `ovf`;
  - `ovf` is set on any accumulation whose carry out of bit `ACC_W`−1 is 1;
  - `ovf` stays set until `nRst` or `clear`.
- When undefined: no `ovf` port, and wrap-around is silent.

## Structure
- Package `acc_pkg` holds:
  - localparam defaults `WORD_W`=32 and `ACC_W`=128;
  - the state enum `acc_state_t` (IDLE, SHIFT, WAIT);
  - the counter width `$clog2(WORD_W)`.
- Sub-module `acc_sipo`: the serial-in/parallel-out shift register plus bit counter, with a `done` pulse and parallel word output.
- The top level contains the FSM, the 128-bit adder and register, and the optional `ovf` logic.

## Test plan
- Reset pulse, then 10 frames of word 0x00000001 with 1000 ns gaps → `big`=10, incrementing by 1 on each LSB edge.
- `clear` held for 50 cycles, released, then 10 frames of 0x10000000 → `big`=0 after clear, then 0xA0000000.
- `clear` held high throughout 10 frames of 0x00000001 → `big` remains 0.
- Protocol errors:
  - `add` dropped after 16 data bits → `big` unchanged;
  - a frame whose start bit is 1 → ignored;
  - `add` held high across two words with no low gap → only the first word is added.
- `nRst` asserted mid-frame, then a clean frame of 0x00000005 → `big`=5.
- With `ACC_OVF_EN` and `ACC_W`=32, frames 0xFFFFFFFF then 0x00000002 → `big`=1, `ovf`=1; `ovf` then cleared by `clear`.
